// File: rtl/led_cmd_parser_pkg.sv
// rtl/led_cmd_parser_pkg.sv - shared constants, state enum and checksum helper
package led_cmd_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CMD,
        ST_DHI,
        ST_DLO
    } state_t;

    localparam logic [7:0] HDR_BYTE    = 8'hA5;
    localparam logic [7:0] ACK_BYTE    = 8'h06;
    localparam logic [7:0] NAK_BYTE    = 8'h15;

    localparam logic [7:0] CMD_PATTERN = 8'h01;
    localparam logic [7:0] CMD_PERIOD  = 8'h02;
    localparam logic [7:0] CMD_CLEAR   = 8'h03;

    function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                              input logic [7:0] dhi,
                                              input logic [7:0] dlo);
        return cmd ^ dhi ^ dlo;
    endfunction

endpackage

// File: rtl/led_cmd_parser_if.sv
// rtl/led_cmd_parser_if.sv - receive byte stream and response handshake bundle
interface led_cmd_parser_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] ack_data;
    logic       ack_valid;
    logic       ack_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  ack_data,
        input  ack_valid,
        output ack_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output ack_data,
        output ack_valid,
        input  ack_ready
    );

endinterface

// File: rtl/led_blinker.sv
// rtl/led_blinker.sv - tick/period/phase blink generator driving the LED bank
module led_blinker #(
    parameter int TICK_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pattern,
    input  logic [7:0] period,
    input  logic       restart,
    output logic [9:0] led
);

    localparam int TICK_W = $clog2(TICK_CYC + 1);

    logic [TICK_W-1:0] tick_cnt;
    logic [7:0]        per_cnt;
    logic              phase;
    logic              tick_wrap;
    logic              per_wrap;

    assign tick_wrap = (tick_cnt == TICK_W'(TICK_CYC - 1));
    // >= guards against a counter left beyond a shorter period
    assign per_wrap  = (period != 8'd0) && (per_cnt >= period - 8'd1);

    // Tick counter, period counter and phase; restart re-aligns the blink
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            tick_cnt <= '0;
            per_cnt  <= '0;
            phase    <= 1'b0;
        end else begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
            if (period == 8'd0) begin
                per_cnt <= '0;
                phase   <= 1'b0;
            end else if (tick_wrap) begin
                if (per_wrap) begin
                    per_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    per_cnt <= per_cnt + 8'd1;
                end
            end
        end
    end

    assign led = ((period == 8'd0) || !phase) ? pattern : 10'd0;

endmodule

// File: rtl/led_cmd_parser.sv
// rtl/led_cmd_parser.sv - framed LED command parser with ACK/NAK response
module led_cmd_parser
    import led_cmd_parser_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int TICK_CYC    = 50000
) (
    input  logic                clk,
    input  logic                rst,
    led_cmd_parser_if.slave     bus,
    output logic [9:0]          led,
    output logic                frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t          state;
    logic [7:0]      cmd_r;
    logic [7:0]      dhi_r;
    logic [7:0]      dlo_r;
    logic [TO_W-1:0] to_cnt;
    logic [9:0]      pattern;
    logic [7:0]      period;
    logic [7:0]      ack_data_r;
    logic            ack_valid_r;
    logic            cmd_known;
    logic            frame_ok;
    logic            csum_take;
    logic            restart;

    assign cmd_known = (cmd_r == CMD_PATTERN) || (cmd_r == CMD_PERIOD) || (cmd_r == CMD_CLEAR);
    assign frame_ok  = cmd_known && (bus.rx_data == frame_csum(cmd_r, dhi_r, dlo_r));
    assign csum_take = bus.rx_valid && (state == ST_DLO);
    assign restart   = csum_take && frame_ok && (cmd_r == CMD_PERIOD);

    // Frame FSM, command execution, response register and inter-byte timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_r       <= '0;
            dhi_r       <= '0;
            dlo_r       <= '0;
            to_cnt      <= '0;
            pattern     <= '0;
            period      <= '0;
            ack_data_r  <= '0;
            ack_valid_r <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (ack_valid_r && bus.ack_ready) begin
                ack_valid_r <= 1'b0;
            end
            if (bus.rx_valid) begin
                // a byte always wins over a coincident timeout
                to_cnt <= '0;
                case (state)
                    ST_IDLE: if (bus.rx_data == HDR_BYTE) state <= ST_HDR;
                    ST_HDR: begin
                        cmd_r <= bus.rx_data;
                        state <= ST_CMD;
                    end
                    ST_CMD: begin
                        dhi_r <= bus.rx_data;
                        state <= ST_DHI;
                    end
                    ST_DHI: begin
                        dlo_r <= bus.rx_data;
                        state <= ST_DLO;
                    end
                    ST_DLO: begin
                        state       <= ST_IDLE;
                        ack_valid_r <= 1'b1;
                        ack_data_r  <= frame_ok ? ACK_BYTE : NAK_BYTE;
                        frame_err   <= !frame_ok;
                        if (frame_ok) begin
                            case (cmd_r)
                                CMD_PATTERN: pattern <= {dhi_r[1:0], dlo_r};
                                CMD_PERIOD:  period  <= dlo_r;
                                default: begin
                                    pattern <= '0;
                                    period  <= '0;
                                end
                            endcase
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    state     <= ST_IDLE;
                    to_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

    assign bus.ack_data  = ack_data_r;
    assign bus.ack_valid = ack_valid_r;

    led_blinker #(
        .TICK_CYC(TICK_CYC)
    ) u_blinker (
        .clk    (clk),
        .rst    (rst),
        .pattern(pattern),
        .period (period),
        .restart(restart),
        .led    (led)
    );

endmodule

// File: tb/tb_led_cmd_parser.sv
// tb/tb_led_cmd_parser.sv - directed self-checking bench for led_cmd_parser
module tb_led_cmd_parser;

    localparam int TO_CYC = 20;
    localparam int TK_CYC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] led;
    logic       frame_err;
    int         n_checks = 0;
    int         n_errors = 0;

    led_cmd_parser_if bus();

    led_cmd_parser #(
        .TIMEOUT_CYC(TO_CYC),
        .TICK_CYC   (TK_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .led      (led),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] s);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(h);
        send_byte(l);
        send_byte(s);
    endtask

    task automatic accept_ack();
        bus.ack_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.ack_ready = 1'b0;
        chk("ack_clear", 32'(bus.ack_valid), 32'd0);
    endtask

    initial begin
        int lat;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.ack_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_ack_valid", 32'(bus.ack_valid), 32'd0);
        chk("rst_ack_data", 32'(bus.ack_data), 32'h00);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;

        // Pattern load with all ten LEDs on
        send_frame(8'h01, 8'h03, 8'hFF, 8'hFD);
        chk("a_ack_valid", 32'(bus.ack_valid), 32'd1);
        chk("a_ack_data", 32'(bus.ack_data), 32'h06);
        chk("a_led", 32'(led), 32'h3FF);
        chk("a_no_err", 32'(frame_err), 32'd0);
        accept_ack();

        // Bad checksum: NAK, error pulse, LED untouched
        send_frame(8'h01, 8'h00, 8'h0F, 8'h00);
        chk("b_ack_data", 32'(bus.ack_data), 32'h15);
        chk("b_frame_err", 32'(frame_err), 32'd1);
        chk("b_led", 32'(led), 32'h3FF);
        @(posedge clk);
        #1;
        chk("b_err_pulse", 32'(frame_err), 32'd0);
        accept_ack();

        // Unknown command with correct checksum is a NAK
        send_frame(8'h07, 8'h00, 8'h01, 8'h06);
        chk("u_ack_data", 32'(bus.ack_data), 32'h15);
        chk("u_led", 32'(led), 32'h3FF);
        accept_ack();

        // Blink: pattern 0x155, period 2 ticks of 4 cycles
        send_frame(8'h01, 8'h01, 8'h55, 8'h55);
        chk("p_led", 32'(led), 32'h155);
        accept_ack();
        send_frame(8'h02, 8'h00, 8'h02, 8'h00);
        chk("k_ack_data", 32'(bus.ack_data), 32'h06);
        chk("k_led_0", 32'(led), 32'h155);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 7)  chk("k_led_7", 32'(led), 32'h155);
            if (k == 8)  chk("k_led_8", 32'(led), 32'h000);
            if (k == 15) chk("k_led_15", 32'(led), 32'h000);
            if (k == 16) chk("k_led_16", 32'(led), 32'h155);
        end
        accept_ack();

        // Clear, then a frame carrying 0xA5 as data
        send_frame(8'h03, 8'h00, 8'h00, 8'h03);
        chk("c_led", 32'(led), 32'h000);
        accept_ack();
        send_frame(8'h01, 8'hA5, 8'h00, 8'hA4);
        chk("r_ack_data", 32'(bus.ack_data), 32'h06);
        chk("r_led", 32'(led), 32'h100);
        accept_ack();

        // Timeout after a partial frame
        send_byte(8'hA5);
        send_byte(8'h01);
        lat = -1;
        for (int i = 1; i <= 3 * TO_CYC; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                lat = i;
                break;
            end
        end
        chk("t_pulse_seen", 32'(lat >= TO_CYC && lat <= TO_CYC + 1), 32'd1);
        chk("t_no_ack", 32'(bus.ack_valid), 32'd0);
        send_frame(8'h01, 8'h00, 8'h0F, 8'h0E);
        chk("t_next_ack", 32'(bus.ack_data), 32'h06);
        chk("t_next_led", 32'(led), 32'h00F);

        // Pending response gets overwritten, then overlaps acceptance
        send_frame(8'h01, 8'h00, 8'hF0, 8'hF1);
        send_frame(8'h01, 8'h00, 8'hAA, 8'hAB);
        chk("o_valid", 32'(bus.ack_valid), 32'd1);
        chk("o_data", 32'(bus.ack_data), 32'h06);
        chk("o_led", 32'(led), 32'h0AA);
        send_frame(8'h01, 8'h00, 8'h11, 8'h22);
        chk("o_nak_valid", 32'(bus.ack_valid), 32'd1);
        chk("o_nak_data", 32'(bus.ack_data), 32'h15);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h33);
        bus.ack_ready = 1'b1;
        send_byte(8'h32);
        chk("s_valid", 32'(bus.ack_valid), 32'd1);
        chk("s_data", 32'(bus.ack_data), 32'h06);
        @(posedge clk);
        #1;
        bus.ack_ready = 1'b0;
        chk("s_clear", 32'(bus.ack_valid), 32'd0);

        // Reset in the middle of a frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("m_led", 32'(led), 32'h000);
        chk("m_no_ack", 32'(bus.ack_valid), 32'd0);
        send_byte(8'h0F);
        send_byte(8'h0E);
        chk("m_stale_ack", 32'(bus.ack_valid), 32'd0);
        send_frame(8'h01, 8'h02, 8'h00, 8'h03);
        chk("m_next_ack", 32'(bus.ack_data), 32'h06);
        chk("m_next_led", 32'(led), 32'h200);
        accept_ack();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
